machine_seg_scroller: RTL and testbench



---
 rtl/machine_seg_pkg.sv | 44 ++++
 rtl/machine_seg_font.sv | 46 ++++
 rtl/machine_seg_scroller.sv | 203 ++++++++++++++++++++
 tb/tb_machine_seg_scroller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/machine_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : machine_seg_pkg
// Description : Shared types and constants for the Machine seven-segment
//               scrolling message driver (state encoding, blank code, glyphs).
//               Segment bit order: bit0=a ... bit6=g, bit7=dp, active-high.
// Revision    : 1.0 - initial release
// ============================================================================
package machine_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } seg_state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Letter and punctuation glyphs
    localparam logic [7:0] GLYPH_H     = 8'h74;
    localparam logic [7:0] GLYPH_E     = 8'h7B;
    localparam logic [7:0] GLYPH_L     = 8'h30;
    localparam logic [7:0] GLYPH_O     = 8'h5C;
    localparam logic [7:0] GLYPH_UNDER = 8'h08;
    localparam logic [7:0] GLYPH_W     = 8'h2A;
    localparam logic [7:0] GLYPH_R     = 8'h31;
    localparam logic [7:0] GLYPH_D     = 8'h5E;
    localparam logic [7:0] GLYPH_BANG  = 8'h82;
    localparam logic [7:0] GLYPH_SPACE = 8'h00;

    // Numeral glyphs (only used when MACHINE_SEG_DIGITS_EN is defined)
    localparam logic [7:0] GLYPH_0 = 8'h3F;
    localparam logic [7:0] GLYPH_1 = 8'h06;
    localparam logic [7:0] GLYPH_2 = 8'h5B;
    localparam logic [7:0] GLYPH_3 = 8'h4F;
    localparam logic [7:0] GLYPH_4 = 8'h66;
    localparam logic [7:0] GLYPH_5 = 8'h6D;
    localparam logic [7:0] GLYPH_6 = 8'h7D;
    localparam logic [7:0] GLYPH_7 = 8'h07;
    localparam logic [7:0] GLYPH_8 = 8'h7F;
    localparam logic [7:0] GLYPH_9 = 8'h6F;

endpackage
`default_nettype wire

// File: rtl/machine_seg_font.sv
`default_nettype none
// ============================================================================
// Module      : machine_seg_font
// Description : Combinational ASCII to seven-segment font. Unknown codes
//               render blank. Define MACHINE_SEG_DIGITS_EN to add '0'..'9'.
// Revision    : 1.0 - initial release
// ============================================================================
module machine_seg_font
    import machine_seg_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [7:0] seg
);

    // Glyph lookup, blank by default
    always_comb begin
        seg = SEG_BLANK;
        case (ascii)
            8'h68: seg = GLYPH_H;      // 'h'
            8'h65: seg = GLYPH_E;      // 'e'
            8'h6C: seg = GLYPH_L;      // 'l'
            8'h6F: seg = GLYPH_O;      // 'o'
            8'h5F: seg = GLYPH_UNDER;  // '_'
            8'h77: seg = GLYPH_W;      // 'w'
            8'h72: seg = GLYPH_R;      // 'r'
            8'h64: seg = GLYPH_D;      // 'd'
            8'h21: seg = GLYPH_BANG;   // '!'
            8'h20: seg = GLYPH_SPACE;  // ' '
`ifdef MACHINE_SEG_DIGITS_EN
            8'h30: seg = GLYPH_0;
            8'h31: seg = GLYPH_1;
            8'h32: seg = GLYPH_2;
            8'h33: seg = GLYPH_3;
            8'h34: seg = GLYPH_4;
            8'h35: seg = GLYPH_5;
            8'h36: seg = GLYPH_6;
            8'h37: seg = GLYPH_7;
            8'h38: seg = GLYPH_8;
            8'h39: seg = GLYPH_9;
`endif
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/machine_seg_scroller.sv
`default_nettype none
// ============================================================================
// Module      : machine_seg_scroller
// Description : Scrolling, time-multiplexed seven-segment message driver.
//               Captures an ASCII message from a byte stream, then shows it
//               on DIGITS multiplexed digits, rotating the window once every
//               SCROLL_DIV cycles when the message is wider than the display.
//               Optional macro MACHINE_SEG_DIGITS_EN adds numeral glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
module machine_seg_scroller
    import machine_seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int MUX_DIV    = 1000,
    parameter int SCROLL_DIV = 250000
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    input  logic              char_last,
    output logic              char_ready,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic              showing
);

    localparam int LEN_W  = $clog2(MSG_DEPTH + 1);
    localparam int ADDR_W = $clog2(MSG_DEPTH);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MUX_W  = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int SCR_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    // Wide enough for offset+index and for comparing len against DIGITS
    localparam int SUM_W  = LEN_W + 4;

    seg_state_e          state_q, state_d;
    logic [LEN_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   offset_q, offset_d;
    logic [SCR_W-1:0]    scroll_cnt_q, scroll_cnt_d;
    logic [MUX_W-1:0]    mux_cnt_q, mux_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                showing_q, showing_d;

    logic [7:0]          msg_buf_q [MSG_DEPTH];
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                refresh;

    logic [SUM_W-1:0]    rd_sum;
    logic [ADDR_W-1:0]   rd_addr;
    logic [7:0]          rd_char;
    logic [7:0]          font_seg;

    assign char_ready = 1'b1;
    assign seg        = seg_q;
    assign an         = an_q;
    assign showing    = showing_q;

    // Message storage; contents are don't-care after reset so no reset here
    always_ff @(posedge system1000) begin
        if (wr_en) begin
            msg_buf_q[wr_addr] <= char_in;
        end
    end

    // Capture FSM, commit logic and scroll/mux counters
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        len_d        = len_q;
        offset_d     = offset_q;
        scroll_cnt_d = scroll_cnt_q;
        mux_cnt_d    = mux_cnt_q;
        idx_d        = idx_q;
        wr_en        = 1'b0;
        wr_addr      = '0;
        refresh      = 1'b0;

        if (char_valid) begin
            wr_en   = 1'b1;
            state_d = ST_LOAD;
            if (state_q == ST_LOAD) begin
                wr_addr  = ADDR_W'(wr_cnt_q);
                wr_cnt_d = wr_cnt_q + LEN_W'(1);
            end else begin
                wr_addr  = '0;
                wr_cnt_d = LEN_W'(1);
            end
            // A full buffer forces the commit even without char_last
            if (char_last || (wr_cnt_d == LEN_W'(MSG_DEPTH))) begin
                state_d      = ST_SHOW;
                len_d        = wr_cnt_d;
                offset_d     = '0;
                scroll_cnt_d = '0;
                mux_cnt_d    = '0;
                idx_d        = '0;
                refresh      = 1'b1;
            end
        end else if (state_q == ST_SHOW) begin
            if (scroll_cnt_q == SCR_W'(SCROLL_DIV - 1)) begin
                scroll_cnt_d = '0;
                if (SUM_W'(len_q) > SUM_W'(DIGITS)) begin
                    if ((LEN_W'(offset_q) + LEN_W'(1)) == len_q) begin
                        offset_d = '0;
                    end else begin
                        offset_d = offset_q + ADDR_W'(1);
                    end
                end
            end else begin
                scroll_cnt_d = scroll_cnt_q + SCR_W'(1);
            end

            if (mux_cnt_q == MUX_W'(MUX_DIV - 1)) begin
                mux_cnt_d = '0;
                refresh   = 1'b1;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end else begin
                mux_cnt_d = mux_cnt_q + MUX_W'(1);
            end
        end
    end

    // Character address for the digit about to be lit: (offset+index) mod len.
    // Both terms are below len when scrolling, so one subtract is enough.
    // Bypass covers a single-character message committed on the same edge.
    always_comb begin
        rd_sum = SUM_W'(offset_d) + SUM_W'(idx_d);
        if (rd_sum >= SUM_W'(len_d)) begin
            rd_sum = rd_sum - SUM_W'(len_d);
        end
        rd_addr = ADDR_W'(rd_sum);
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_char = char_in;
        end else begin
            rd_char = msg_buf_q[rd_addr];
        end
    end

    machine_seg_font u_font (
        .ascii (rd_char),
        .seg   (font_seg)
    );

    // Registered display outputs; seg and an update together on a refresh
    always_comb begin
        seg_d     = seg_q;
        an_d      = an_q;
        showing_d = showing_q;
        if (state_d == ST_SHOW) begin
            showing_d = 1'b1;
            if (refresh) begin
                an_d = DIGITS'(1) << idx_d;
                if (SUM_W'(idx_d) >= SUM_W'(len_d)) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = font_seg;
                end
            end
        end else begin
            showing_d = 1'b0;
            an_d      = '0;
            seg_d     = SEG_BLANK;
        end
    end

    // State and counter registers
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            len_q        <= '0;
            offset_q     <= '0;
            scroll_cnt_q <= '0;
            mux_cnt_q    <= '0;
            idx_q        <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= '0;
            showing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            len_q        <= len_d;
            offset_q     <= offset_d;
            scroll_cnt_q <= scroll_cnt_d;
            mux_cnt_q    <= mux_cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            showing_q    <= showing_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_machine_seg_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_machine_seg_scroller
// Description : Self-checking bench for machine_seg_scroller. Display output
//               is predicted from elapsed cycles since commit. Honours
//               MACHINE_SEG_DIGITS_EN for the numeral glyphs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_machine_seg_scroller;

    localparam int DIGITS     = 4;
    localparam int MSG_DEPTH  = 16;
    localparam int MUX_DIV    = 2;
    localparam int SCROLL_DIV = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [7:0]        char_in = 8'h00;
    logic              char_valid = 1'b0;
    logic              char_last = 1'b0;
    logic              char_ready;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;
    logic              showing;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] pend_q  [$];   // characters of the message being captured
    logic [7:0] shown_q [$];   // committed message
    bit         committed;

    always #5 clk = ~clk;

    machine_seg_scroller #(
        .DIGITS     (DIGITS),
        .MSG_DEPTH  (MSG_DEPTH),
        .MUX_DIV    (MUX_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .char_in         (char_in),
        .char_valid      (char_valid),
        .char_last       (char_last),
        .char_ready      (char_ready),
        .seg             (seg),
        .an              (an),
        .showing         (showing)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_font(input logic [7:0] c);
        case (c)
            "h": return 8'h74;
            "e": return 8'h7B;
            "l": return 8'h30;
            "o": return 8'h5C;
            "_": return 8'h08;
            "w": return 8'h2A;
            "r": return 8'h31;
            "d": return 8'h5E;
            "!": return 8'h82;
`ifdef MACHINE_SEG_DIGITS_EN
            "0": return 8'h3F;
            "1": return 8'h06;
            "2": return 8'h5B;
            "3": return 8'h4F;
            "4": return 8'h66;
            "5": return 8'h6D;
            "6": return 8'h7D;
            "7": return 8'h07;
            "8": return 8'h7F;
            "9": return 8'h6F;
`endif
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_blank(input string tag);
        check_eq({tag, ".showing"}, 32'(showing), 32'd0);
        check_eq({tag, ".an"}, 32'(an), 32'd0);
        check_eq({tag, ".seg"}, 32'(seg), 32'd0);
        check_eq({tag, ".ready"}, 32'(char_ready), 32'd1);
    endtask

    // Called at a negedge; presents one character, returns at the negedge
    // after it transferred and updates the message model.
    task automatic send(input logic [7:0] c, input bit last);
        char_in    = c;
        char_last  = last;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        char_last  = 1'b0;
        pend_q.push_back(c);
        if (last || pend_q.size() == MSG_DEPTH) begin
            shown_q   = pend_q;
            pend_q    = {};
            committed = 1'b1;
        end else begin
            committed = 1'b0;
        end
    endtask

    // Cycle n after commit: digit k=(n/MUX_DIV)%DIGITS, latched at the start
    // of its slot r, showing the window offset reached after r cycles.
    task automatic show_check(input string tag, input int ncyc);
        int len;
        len = shown_q.size();
        for (int n = 0; n < ncyc; n++) begin
            int r, k, off;
            logic [7:0] exp_seg;
            r   = (n / MUX_DIV) * MUX_DIV;
            k   = (n / MUX_DIV) % DIGITS;
            off = (len > DIGITS) ? ((r / SCROLL_DIV) % len) : 0;
            exp_seg = (k < len) ? ref_font(shown_q[(off + k) % len]) : 8'h00;
            check_eq({tag, ".showing"}, 32'(showing), 32'd1);
            check_eq({tag, ".an"}, 32'(an), 32'd1 << k);
            check_eq({tag, ".seg"}, 32'(seg), 32'(exp_seg));
            @(negedge clk);
        end
    endtask

    task automatic send_str(input string s, input int ncyc);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], i == s.len() - 1);
            if (!committed) check_blank({"load_", s});
        end
        show_check({"show_", s}, ncyc);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        string pool;
        pool = "helo_wrd! 0123456789AZ";

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check_blank("reset");
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_blank("idle");
        end

        // Static, scrolling, reload and numeral messages
        send_str("he", 40);
        send_str("hello_world!", 12 * SCROLL_DIV + 3 * DIGITS * MUX_DIV);
        send_str("wd", 24);
        send_str("42", 16);
        send_str("o", 16);

        // Overflow: 16 chars force a commit, the 17th starts a new message
        for (int i = 0; i < MSG_DEPTH; i++) send(pool[i % 9], 1'b0);
        check_eq("ovf.committed", 32'(committed), 32'd1);
        show_check("ovf_show", 2 * SCROLL_DIV);
        send("r", 1'b0);
        check_blank("ovf_load1");
        send("d", 1'b0);
        check_blank("ovf_load2");
        send("!", 1'b1);
        show_check("ovf_tail", 16);

        // Randomized messages with gaps, some overflowing
        for (int m = 0; m < 24; m++) begin
            int len;
            len = $urandom_range(1, MSG_DEPTH + 3);
            for (int i = 0; i < len; i++) begin
                send(pool[$urandom_range(0, pool.len() - 1)], i == len - 1);
                if (committed && i != len - 1) begin
                    show_check("rnd_ovf", 3);
                end else if (!committed) begin
                    check_blank("rnd_load");
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clk);
                        check_blank("rnd_gap");
                    end
                end
            end
            show_check("rnd_show", $urandom_range(20, 100));
        end

        // Asynchronous reset in the middle of a displayed message
        send_str("hello_world!", 10);
        #2 rstn = 1'b0;
        #1 check_blank("async_rst");
        @(negedge clk);
        rstn = 1'b1;
        pend_q = {};
        @(negedge clk);
        check_blank("post_rst");
        send_str("led", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
